// File: rtl/alarm_trigger.sv
// alarm_trigger: holds the armed flag, detects the once-per-second alarm match
// and runs the ring / snooze / stop state machine that drives the buzzer.
// Optional feature macro: ALARM_SNOOZE_EN. When it is undefined, the snooze
// state and its countdown are not built and snooze_button is ignored.
module alarm_trigger #(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300,
    parameter int MAX_SNOOZE     = 3,
    localparam int SC_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sec_tick,
    input  logic [4:0]      cur_hours,
    input  logic [5:0]      cur_minutes,
    input  logic [5:0]      cur_seconds,
    input  logic [4:0]      alarm_hours,
    input  logic [5:0]      alarm_minutes,
    input  logic            on_off_alarm,
    input  logic            ack_flag,
    input  logic            stop_button,
    input  logic            snooze_button,
    output logic            armed,
    output logic            buzzer,
    output logic            ringing,
    output logic            snoozing,
    output logic [SC_W-1:0] snooze_count
);

    localparam int RC_W = (RING_SECONDS > 1) ? $clog2(RING_SECONDS) : 1;
    localparam logic [RC_W-1:0] RING_LAST = RC_W'(RING_SECONDS - 1);
    localparam logic [SC_W-1:0] MAX_SC    = SC_W'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
`ifdef ALARM_SNOOZE_EN
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
`else
        ST_RINGING = 2'd1
`endif
    } state_t;

    state_t            state_reg, state_next;
    logic [RC_W-1:0]   ring_cnt_reg, ring_cnt_next;
    logic              beep_phase_reg, beep_phase_next;
    logic [SC_W-1:0]   snooze_count_reg, snooze_count_next;
    logic              armed_reg, armed_next;
    logic              on_off_d_reg;
    logic              buzzer_reg;

`ifdef ALARM_SNOOZE_EN
    localparam int SZ_W = $clog2(SNOOZE_SECONDS + 1);
    localparam logic [SZ_W-1:0] SNZ_LOAD = SZ_W'(SNOOZE_SECONDS);
    logic [SZ_W-1:0]   snz_cnt_reg, snz_cnt_next;
`else
    // Without snooze hardware these inputs have no load.
    logic unused_snooze;
    assign unused_snooze = snooze_button ^ (SNOOZE_SECONDS > 0);
`endif

    logic toggle;
    logic disarm;
    logic time_match;
    logic match;

    // Arm toggling on the rising edge of the setting stage's request level,
    // and the per-second alarm match (out-of-range alarm times never match).
    always_comb begin
        toggle     = on_off_alarm & ~on_off_d_reg;
        armed_next = armed_reg ^ toggle;
        disarm     = armed_reg & toggle;
        time_match = (cur_hours == alarm_hours) && (cur_minutes == alarm_minutes) &&
                     (cur_seconds == 6'd0) && (alarm_hours <= 5'd23) &&
                     (alarm_minutes <= 6'd59);
        match      = sec_tick & armed_reg & ~ack_flag & time_match;
    end

    // Next-state logic; disarm overrides everything, then stop, snooze, tick.
    always_comb begin
        state_next        = state_reg;
        ring_cnt_next     = ring_cnt_reg;
        beep_phase_next   = beep_phase_reg;
        snooze_count_next = snooze_count_reg;
`ifdef ALARM_SNOOZE_EN
        snz_cnt_next      = snz_cnt_reg;
`endif
        if (disarm) begin
            state_next        = ST_IDLE;
            snooze_count_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (match) begin
                        state_next        = ST_RINGING;
                        ring_cnt_next     = '0;
                        beep_phase_next   = 1'b1;
                        snooze_count_next = '0;
                    end
                end
                ST_RINGING: begin
                    if (stop_button) begin
                        state_next        = ST_IDLE;
                        snooze_count_next = '0;
`ifdef ALARM_SNOOZE_EN
                    end else if (snooze_button && (snooze_count_reg < MAX_SC)) begin
                        state_next        = ST_SNOOZE;
                        snooze_count_next = snooze_count_reg + 1'b1;
                        snz_cnt_next      = SNZ_LOAD;
`endif
                    end else if (sec_tick) begin
                        // Exit on the tick that would complete RING_SECONDS ticks.
                        if (ring_cnt_reg == RING_LAST) begin
                            state_next        = ST_IDLE;
                            snooze_count_next = '0;
                        end else begin
                            ring_cnt_next   = ring_cnt_reg + 1'b1;
                            beep_phase_next = ~beep_phase_reg;
                        end
                    end
                end
`ifdef ALARM_SNOOZE_EN
                ST_SNOOZE: begin
                    if (stop_button) begin
                        state_next        = ST_IDLE;
                        snooze_count_next = '0;
                    end else if (sec_tick) begin
                        if (snz_cnt_reg <= SZ_W'(1)) begin
                            state_next      = ST_RINGING;
                            ring_cnt_next   = '0;
                            beep_phase_next = 1'b1;
                            snz_cnt_next    = '0;
                        end else begin
                            snz_cnt_next = snz_cnt_reg - 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_next        = ST_IDLE;
                    snooze_count_next = '0;
                end
            endcase
        end
    end

    // State, counters and the registered buzzer drive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= ST_IDLE;
            ring_cnt_reg     <= '0;
            beep_phase_reg   <= 1'b0;
            snooze_count_reg <= '0;
            armed_reg        <= 1'b0;
            on_off_d_reg     <= 1'b0;
            buzzer_reg       <= 1'b0;
        end else begin
            state_reg        <= state_next;
            ring_cnt_reg     <= ring_cnt_next;
            beep_phase_reg   <= beep_phase_next;
            snooze_count_reg <= snooze_count_next;
            armed_reg        <= armed_next;
            on_off_d_reg     <= on_off_alarm;
            buzzer_reg       <= (state_next == ST_RINGING) & beep_phase_next;
        end
    end

`ifdef ALARM_SNOOZE_EN
    // Snooze countdown register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snz_cnt_reg <= '0;
        end else begin
            snz_cnt_reg <= snz_cnt_next;
        end
    end

    assign snoozing     = (state_reg == ST_SNOOZE);
    assign snooze_count = snooze_count_reg;
`else
    assign snoozing     = 1'b0;
    assign snooze_count = snooze_count_reg;
`endif

    assign armed   = armed_reg;
    assign buzzer  = buzzer_reg;
    assign ringing = (state_reg == ST_RINGING);

endmodule
